// File: rtl/fifo_nibble_uart_tx.sv
// Drains a nibble FIFO two words at a time (low nibble first) and sends each byte as an
// 8N1 frame, CLKS_PER_BIT clocks per bit; waits in REQ_HI with the line idle if the FIFO runs dry.
module fifo_nibble_uart_tx #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_rd_en,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int BITS   = 2 * WIDTH;
  localparam int BIT_W  = $clog2(BITS);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BITS - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_LO, REQ_HI, WAIT_HI, START, DATA, STOP
  } state_t;

  state_t            state_q, state_d;
  logic [BITS-1:0]   data_q, data_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic              rd_en_q, rd_en_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              baud_last;

  assign baud_last = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    rd_en_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          rd_en_d = 1'b1;
          state_d = WAIT_LO;
        end
      end
      // The strobe is on the wire this cycle and the FIFO presents the word alongside it.
      WAIT_LO: begin
        data_d[WIDTH-1:0] = fifo_rdata;
        state_d           = REQ_HI;
      end
      REQ_HI: begin
        if (!fifo_empty) begin
          rd_en_d = 1'b1;
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        data_d[BITS-1:WIDTH] = fifo_rdata;
        bit_d                = '0;
        baud_d               = '0;
        state_d              = START;
      end
      START: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are computed from the next state so the flops line up with the state they describe.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[bit_d];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (baud_d == BAUD_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
      rd_en_q <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      rd_en_q <= rd_en_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_nibble_uart_tx.sv
// Bench: queue-based upstream FIFO, byte/frame reference model and a per-cycle line checker.
module tb_fifo_nibble_uart_tx;

  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;

  logic       clk;
  logic       rst_n;
  logic       fifo_empty;
  logic [3:0] fifo_rdata;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;
  logic       frame_done;

  fifo_nibble_uart_tx #(.WIDTH(4), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  int n_checks;
  int n_pass;
  int cyc;

  logic [3:0] nq[$];         // upstream FIFO contents
  logic [7:0] exp_bytes[$];  // bytes the model says must go out, in order
  logic [9:0] rx_log[$];     // frames as seen on the line, bit i = i-th bit time
  int         rd_cnt, fd_cnt, frames;
  bit         pop_pend, half;
  logic [3:0] lo_nib;

  bit         in_frame;
  int         k, idle_run, last_gap, start_cyc, fd_cyc;
  logic [7:0] cur;
  logic [9:0] rx_cur;
  logic       exp_bit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic push(input logic [3:0] v);
    nq.push_back(v);
  endtask

  function automatic logic [9:0] rx_at(input int i);
    if (i >= 0 && i < rx_log.size()) return rx_log[i];
    return 'x;
  endfunction

  task automatic wait_frames(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (frames < target && n < budget) begin
      step();
      n++;
    end
    check(name, frames, target);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Upstream FIFO: the word is presented while the strobe is high and popped once it drops.
  initial begin
    fifo_empty = 1'b1;
    fifo_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (pop_pend && nq.size() > 0) void'(nq.pop_front());
      pop_pend = 1'b0;
      if (!rst_n) begin
        half = 1'b0;
        exp_bytes.delete();
      end
      fifo_rdata = 4'($urandom_range(0, 15));
      if (fifo_rd_en === 1'b1) begin
        rd_cnt++;
        check("rd_has_data", nq.size() > 0, 1'b1);
        if (nq.size() > 0) begin
          fifo_rdata = nq[0];
          pop_pend   = 1'b1;
          if (!half) begin
            lo_nib = nq[0];
            half   = 1'b1;
          end else begin
            exp_bytes.push_back({nq[0], lo_nib});
            half = 1'b0;
          end
        end
      end
      fifo_empty = (nq.size() == 0);
    end
  end

  // Line checker: every frame must be start, model byte LSB first, stop, each CPB cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        in_frame = 1'b0;
        k        = 0;
        idle_run = 0;
      end else begin
        check("rd_en_while_empty", fifo_rd_en & fifo_empty, 1'b0);
        if (frame_done === 1'b1) begin
          fd_cnt++;
          fd_cyc = cyc;
        end
        if (!in_frame && tx === 1'b0) begin
          last_gap  = idle_run;
          idle_run  = 0;
          start_cyc = cyc;
          k         = 0;
          rx_cur    = '0;
          check("start_has_byte", exp_bytes.size() > 0, 1'b1);
          if (exp_bytes.size() > 0) cur = exp_bytes.pop_front();
          else cur = 8'h00;
          in_frame = 1'b1;
        end
        if (in_frame) begin
          if (k < CPB) exp_bit = 1'b0;
          else if (k >= 9 * CPB) exp_bit = 1'b1;
          else exp_bit = cur[(k - CPB) / CPB];
          check("tx_bit", tx, exp_bit);
          check("busy_in_frame", busy, 1'b1);
          check("frame_done_timing", frame_done, k == FRAME - 1);
          if (k % CPB == CPB / 2) rx_cur[k / CPB] = tx;
          k++;
          if (k == FRAME) begin
            in_frame = 1'b0;
            frames++;
            rx_log.push_back(rx_cur);
          end
        end else begin
          check("frame_done_idle", frame_done, 1'b0);
          idle_run++;
        end
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: actual=running required=finished at cycle %0d", cyc);
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, n, rd0, fd0, f0, pushed;
    logic [9:0] fr;

    rst_n = 1'b0;
    repeat (3) step();
    check("rst_tx", tx, 1'b1);
    check("rst_rd_en", fifo_rd_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    rst_n = 1'b1;

    bad = 0;
    repeat (100) begin
      step();
      if (fifo_rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("idle_empty_100", bad, 0);

    rd0 = rd_cnt;
    fd0 = fd_cnt;
    push(4'h5);
    push(4'hA);
    wait_frames(1, 400, "frame_a5_done");
    check("a5_rd_pulses", rd_cnt - rd0, 2);
    check("a5_frame_done_pulses", fd_cnt - fd0, 1);
    check("a5_bits", rx_at(0), 10'b1101001010);
    check("a5_frame_len", fd_cyc - start_cyc + 1, 160);

    push(4'h3);
    repeat (10) step();
    bad = 0;
    repeat (50) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b1 || fifo_rd_en !== 1'b0) bad++;
    end
    check("req_hi_wait", bad, 0);
    push(4'hC);
    wait_frames(2, 400, "frame_c3_done");
    fr = rx_at(1);
    check("c3_byte", fr[8:1], 8'hC3);

    rd0 = rd_cnt;
    push(4'h1);
    push(4'h2);
    push(4'h3);
    push(4'h4);
    wait_frames(4, 800, "frames_b2b_done");
    fr = rx_at(2);
    check("b2b_byte0", fr[8:1], 8'h21);
    fr = rx_at(3);
    check("b2b_byte1", fr[8:1], 8'h43);
    check("b2b_gap_le4", last_gap <= 4, 1'b1);
    check("b2b_rd_pulses", rd_cnt - rd0, 4);

    push(4'h6);
    push(4'h9);
    n = 0;
    while (!(in_frame && k >= 4 * CPB + CPB / 2) && n < 400) begin
      step();
      n++;
    end
    check("reached_bit3", in_frame && k >= 4 * CPB + CPB / 2, 1'b1);
    check("bit3_before_reset", tx, 1'b0);
    rst_n = 1'b0;
    #1;
    check("async_tx", tx, 1'b1);
    check("async_busy", busy, 1'b0);
    repeat (2) step();
    check("rst_mid_rd_en", fifo_rd_en, 1'b0);
    check("rst_mid_frame_done", frame_done, 1'b0);
    rst_n = 1'b1;
    step();
    rd0 = rd_cnt;
    push(4'h7);
    push(4'hE);
    wait_frames(5, 400, "frame_after_reset_done");
    fr = rx_at(4);
    check("post_reset_byte", fr[8:1], 8'hE7);
    check("post_reset_rd_pulses", rd_cnt - rd0, 2);

    rd0    = rd_cnt;
    fd0    = fd_cnt;
    f0     = frames;
    pushed = 0;
    n      = 0;
    while (frames < f0 + 200 && n < 70000) begin
      step();
      n++;
      if ($urandom_range(0, 87) == 0 && nq.size() < 4) begin
        push(4'($urandom_range(0, 15)));
        pushed++;
      end
    end
    check("random_frames", frames, f0 + 200);
    if (pushed % 2 != 0) push(4'($urandom_range(0, 15)));
    n = 0;
    while ((nq.size() > 0 || busy === 1'b1 || in_frame) && n < 2000) begin
      step();
      n++;
    end
    check("random_drained", busy, 1'b0);
    check("random_rd_vs_frames", rd_cnt - rd0, 2 * (fd_cnt - fd0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
